// File: rtl/if_id_queue.sv
// if_id_queue: IF->ID instruction buffer (circular FIFO of DEPTH entries).
// Fetch runs ahead while decode stalls; flush empties the queue in one cycle.
// Ports:
//   clk, rst (async active-low), flush_i
//   in_valid_i / in_ready_o   : fetch-side handshake, payload inst_i, inst_addr_i,
//                               int_flag_i, predict_taken_i, predict_addr_i
//   out_valid_o / out_ready_i : decode-side handshake, payload inst_o, inst_addr_o,
//                               int_flag_o, predict_taken_o, predict_addr_o
//   count_o                   : current occupancy
// All outputs are functions of registered state only (no input-to-output paths).
module if_id_queue #(
  parameter int unsigned        DEPTH    = 2,
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INT_W    = 8,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013,
  parameter logic [INT_W-1:0]   INT_NONE = '0,
  parameter int unsigned        CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic              predict_taken_i,
  input  logic [ADDR_W-1:0] predict_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic              predict_taken_o,
  output logic [ADDR_W-1:0] predict_addr_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [INT_W-1:0]  int_flag;
    logic              predict_taken;
    logic [ADDR_W-1:0] predict_addr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] count;

  logic   push;
  logic   pop;
  entry_t in_entry;
  entry_t head;

  // Ready depends on occupancy only, so a full queue refuses a push even while popping.
  assign in_ready_o  = (count != CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  assign in_entry = '{inst:          inst_i,
                      addr:          inst_addr_i,
                      int_flag:      int_flag_i,
                      predict_taken: predict_taken_i,
                      predict_addr:  predict_addr_i};

  // Entry storage: not reset, and a write is suppressed when flush wins.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem[wp] <= in_entry;
    end
  end

  // Pointers and occupancy; flush has priority over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head payload, masked to the empty defaults so a stale entry is never shown.
  always_comb begin
    head            = mem[rp];
    inst_o          = NOP_INST;
    inst_addr_o     = '0;
    int_flag_o      = INT_NONE;
    predict_taken_o = 1'b0;
    predict_addr_o  = '0;
    if (out_valid_o) begin
      inst_o          = head.inst;
      inst_addr_o     = head.addr;
      int_flag_o      = head.int_flag;
      predict_taken_o = head.predict_taken;
      predict_addr_o  = head.predict_addr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue (DEPTH=2): directed stimulus feeds a scoreboard queue,
// a negedge monitor pops and compares every head the DUT hands to decode.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
    logic        pt;
    logic [31:0] pa;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [7:0]  int_flag_i;
  logic        predict_taken_i;
  logic [31:0] predict_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;
  logic        predict_taken_o;
  logic [31:0] predict_addr_o;
  logic [1:0]  count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  int   mdl_cnt = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .int_flag_i(int_flag_i),
    .predict_taken_i(predict_taken_i), .predict_addr_i(predict_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .int_flag_o(int_flag_o),
    .predict_taken_o(predict_taken_o), .predict_addr_o(predict_addr_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, compare valid against the scoreboard and the head on a pop.
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", 128'(out_valid_o), 128'(sb.size() != 0));
      if (out_valid_o) begin
        if (out_ready_i && !flush_i) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got inst %h expected none", inst_o);
          end else begin
            ent_t e;
            e = sb.pop_front();
            chk("head_payload",
                128'({inst_o, inst_addr_o, int_flag_o, predict_taken_o, predict_addr_o}),
                128'(e));
          end
        end
      end else begin
        chk("empty_payload",
            128'({inst_o, inst_addr_o, int_flag_o, predict_taken_o, predict_addr_o}),
            128'({NOP, 32'h0, 8'h00, 1'b0, 32'h0}));
      end
    end
  end

  // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                      input logic [7:0] intf, input logic pt, input logic [31:0] pa,
                      input logic rdy, input logic fl);
    logic push;
    logic pop;
    ent_t e;
    in_valid_i      = v;
    inst_i          = inst;
    inst_addr_i     = addr;
    int_flag_i      = intf;
    predict_taken_i = pt;
    predict_addr_i  = pa;
    out_ready_i     = rdy;
    flush_i         = fl;
    chk("in_ready", 128'(in_ready_o), 128'(mdl_cnt != DEPTH));
    chk("count", 128'(count_o), 128'(mdl_cnt));
    push = v && (mdl_cnt != DEPTH);
    pop  = rdy && (mdl_cnt != 0);
    e    = '{inst: inst, addr: addr, intf: intf, pt: pt, pa: pa};
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      mdl_cnt = 0;
    end else begin
      if (push) sb.push_back(e);
      mdl_cnt = mdl_cnt + int'(push) - int'(pop);
    end
  endtask

  task automatic push_simple(input logic [31:0] inst, input logic [31:0] addr, input logic rdy);
    step(1'b1, inst, addr, 8'h00, 1'b0, 32'h0, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'hdeadbeef, 32'hdead0000, 8'hee, 1'b1, 32'hbad0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    inst_i = '0;
    inst_addr_i = '0;
    int_flag_i = '0;
    predict_taken_i = 1'b0;
    predict_addr_i = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_inst", 128'(inst_o), 128'(NOP));
    chk("rst_rest", 128'({inst_addr_o, int_flag_o, predict_taken_o, predict_addr_o}), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b0);

    // Fill with decode stalled; third push refused
    push_simple(32'h00100093, 32'h0, 1'b0);
    push_simple(32'h00200113, 32'h4, 1'b0);
    chk("full_head", 128'({inst_o, inst_addr_o}), 128'({32'h00100093, 32'h0}));
    push_simple(32'h00300193, 32'h8, 1'b0);
    idle(1'b0);
    chk("stall_head", 128'({inst_o, inst_addr_o}), 128'({32'h00100093, 32'h0}));

    // Full: pop and push together, push rejected, count 2->1
    push_simple(32'h00400213, 32'hc, 1'b1);
    chk("after_full_pop_count", 128'(count_o), 128'(1));
    chk("second_head", 128'(inst_o), 128'(32'h00200113));
    idle(1'b1);

    // Streaming 8 instructions (pointer wrap)
    for (int i = 0; i < 8; i++) begin
      push_simple(32'h00000013 + 32'(i << 20), 32'h100 + 32'(i * 4), 1'b1);
    end
    idle(1'b1);

    // Flush at count=2 with a push in the same cycle
    push_simple(32'h11111111, 32'h200, 1'b0);
    push_simple(32'h22222222, 32'h204, 1'b0);
    step(1'b1, 32'h33333333, 32'h208, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_inst", 128'(inst_o), 128'(NOP));

    // Flush at count=1 with push and pop requested: both discarded
    push_simple(32'h44444444, 32'h300, 1'b0);
    step(1'b1, 32'h55555555, 32'h304, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Sideband fields pass through unchanged
    step(1'b1, 32'h00a00513, 32'h40, 8'h01, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("side_fields", 128'({int_flag_o, predict_taken_o, predict_addr_o}),
        128'({8'h01, 1'b1, 32'h80}));
    idle(1'b1);

    // Asynchronous reset mid-stream
    push_simple(32'h66666666, 32'h500, 1'b0);
    push_simple(32'h77777777, 32'h504, 1'b0);
    in_valid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid_o), 128'(0));
    chk("arst_count", 128'(count_o), 128'(0));
    chk("arst_in_ready", 128'(in_ready_o), 128'(1));
    chk("arst_payload",
        128'({inst_o, inst_addr_o, int_flag_o, predict_taken_o, predict_addr_o}),
        128'({NOP, 32'h0, 8'h00, 1'b0, 32'h0}));
    sb.delete();
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1'b1);
    push_simple(32'h00b00593, 32'h44, 1'b1);
    idle(1'b1);

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
